// File: rtl/output_layer_mac_if.sv
// Handshake and memory bus for the serial output-layer MAC.
// Weights are read combinationally at w_addr; biases are sampled at start.
interface output_layer_mac_if #(
  parameter int AW = 6
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [AW-1:0] w_addr;
  logic [79:0]   w_data;
  logic [79:0]   b_data;
  logic [79:0]   scores;
  logic          out_valid;
  logic          busy;

  modport master (
    output start,
    output in_valid,
    output in_data,
    output w_data,
    output b_data,
    input  in_ready,
    input  w_addr,
    input  scores,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_data,
    input  w_data,
    input  b_data,
    output in_ready,
    output w_addr,
    output scores,
    output out_valid,
    output busy
  );
endinterface

// File: rtl/output_layer_mac.sv
// Serial dense output layer: ten parallel signed MACs over N_IN activations,
// then bias-included accumulators are shifted, ReLU'd and saturated to 8 bits.
module output_layer_mac #(
  parameter int N_IN  = 64,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7,
  parameter int AW    = $clog2(N_IN)
) (
  input  logic               clk,
  input  logic               rst_n,
  output_layer_mac_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    POST
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] SAT = ACC_W'(255);

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q [10];
  logic signed [ACC_W-1:0] acc_d [10];
  logic [79:0]             scores_q, scores_d;
  logic                    out_valid_q, out_valid_d;

  logic                    fire;
  logic signed [16:0]      prod [10];
  logic signed [ACC_W-1:0] t    [10];

  assign fire = bus.in_valid && (state_q == ACCUM);

  // Activation is unsigned: zero-extend it so the product stays signed.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      prod[k] = $signed({9'b0, bus.in_data})
              * $signed({{9{bus.w_data[8*k+7]}},
                         bus.w_data[8*k +: 8]});
      t[k] = acc_q[k] >>> SHIFT;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    scores_d    = scores_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int k = 0; k < 10; k++) begin
            acc_d[k] = {{(ACC_W-8){bus.b_data[8*k+7]}},
                        bus.b_data[8*k +: 8]};
          end
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (fire) begin
          for (int k = 0; k < 10; k++) begin
            acc_d[k] = acc_q[k] + ACC_W'(prod[k]);
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = POST;
          end
        end
      end
      POST: begin
        for (int k = 0; k < 10; k++) begin
          if (t[k] < 0) begin
            scores_d[8*k +: 8] = 8'd0;
          end else if (t[k] > SAT) begin
            scores_d[8*k +: 8] = 8'd255;
          end else begin
            scores_d[8*k +: 8] = t[k][7:0];
          end
        end
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      scores_q    <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 10; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scores_q    <= scores_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < 10; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.w_addr    = cnt_q;
  assign bus.scores    = scores_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_output_layer_mac.sv
// Scoreboard bench for output_layer_mac with N_IN=4, SHIFT=2.
// Expected score vectors are hand-computed constants queued at issue time.
module tb_output_layer_mac;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  logic [79:0] sb [$];

  output_layer_mac_if #(.AW(2)) ifc ();

  output_layer_mac #(
    .N_IN (4),
    .ACC_W(24),
    .SHIFT(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  localparam logic [79:0] W_RAMP = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5,
                                    8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [79:0] EXP_BASIC = {8'd90, 8'd80, 8'd70, 8'd60, 8'd50,
                                       8'd40, 8'd30, 8'd20, 8'd10, 8'd0};
  localparam logic [79:0] W_CLAMP = {8'd127, 8'd8, 8'd7, 8'd6, 8'd0,
                                     8'd4, 8'd3, 8'd2, 8'd1, 8'hFF};
  localparam logic [79:0] B_CLAMP = {8'd127, 8'd0, 8'd0, 8'd0, 8'hFC,
                                     8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [79:0] EXP_CLAMP_A = {8'd255, 8'd80, 8'd70, 8'd60, 8'd0,
                                         8'd40, 8'd30, 8'd20, 8'd10, 8'd0};
  localparam logic [79:0] EXP_CLAMP_B = {8'd255, 8'd255, 8'd255, 8'd255, 8'd0,
                                         8'd255, 8'd255, 8'd255, 8'd255, 8'd0};
  localparam logic [79:0] EXP_BIAS = {8'd24, 8'd22, 8'd19, 8'd16, 8'd13,
                                      8'd11, 8'd8, 8'd5, 8'd2, 8'd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid scores=%h", ifc.scores);
      end else begin
        chk("scores", ifc.scores, sb.pop_front());
      end
    end
  end

  task automatic do_start();
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input int idx);
    int n;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    @(negedge clk);
    n = 0;
    while (!ifc.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    chk("w_addr", 80'(ifc.w_addr), 80'(idx));
    chk("busy_accum", 80'(ifc.busy), 80'd1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'($urandom);
  endtask

  task automatic stream(input logic [31:0] d, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_beat(d[8*i +: 8], i);
      if (i < 3) begin
        repeat (gap) begin
          ifc.in_valid = 1'b0;
          @(negedge clk);
          chk("w_addr_hold", 80'(ifc.w_addr), 80'(i + 1));
          chk("busy_gap", 80'(ifc.busy), 80'd1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL result_timeout pending=%0d expected=0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    repeat (4) begin
      ifc.start    = 1'($urandom);
      ifc.in_valid = 1'($urandom);
      ifc.in_data  = 8'($urandom);
      ifc.w_data   = {$urandom, $urandom, 16'($urandom)};
      ifc.b_data   = {$urandom, $urandom, 16'($urandom)};
      @(negedge clk);
    end
    chk("rst_scores", ifc.scores, 80'd0);
    chk("rst_out_valid", 80'(ifc.out_valid), 80'd0);
    chk("rst_in_ready", 80'(ifc.in_ready), 80'd0);
    chk("rst_busy", 80'(ifc.busy), 80'd0);
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'd0;
    ifc.w_data   = '0;
    ifc.b_data   = '0;
    rst_n        = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_scores", ifc.scores, 80'd0);
    chk("idle_in_ready", 80'(ifc.in_ready), 80'd0);
    chk("idle_busy", 80'(ifc.busy), 80'd0);
    @(posedge clk);
    #1;

    // Basic inference with pulse timing checks.
    ifc.w_data = W_RAMP;
    sb.push_back(EXP_BASIC);
    do_start();
    stream({8'd10, 8'd10, 8'd10, 8'd10}, 0);
    @(negedge clk);
    chk("post_no_ov", 80'(ifc.out_valid), 80'd0);
    chk("post_busy", 80'(ifc.busy), 80'd1);
    @(negedge clk);
    chk("ov_pulse", 80'(ifc.out_valid), 80'd1);
    chk("ov_busy", 80'(ifc.busy), 80'd0);
    @(negedge clk);
    chk("ov_single", 80'(ifc.out_valid), 80'd0);
    chk("hold_scores", ifc.scores, EXP_BASIC);
    wait_done();

    // Clamping: ReLU, saturation, negative bias.
    ifc.w_data = W_CLAMP;
    ifc.b_data = B_CLAMP;
    sb.push_back(EXP_CLAMP_A);
    do_start();
    stream({8'd10, 8'd10, 8'd10, 8'd10}, 0);
    wait_done();
    sb.push_back(EXP_CLAMP_B);
    do_start();
    stream({8'd255, 8'd255, 8'd255, 8'd255}, 0);
    wait_done();

    // Bias sampled at start only; truncating shift.
    ifc.w_data = W_RAMP;
    ifc.b_data = W_RAMP;
    sb.push_back(EXP_BIAS);
    do_start();
    ifc.b_data = {10{8'h80}};
    stream({8'd4, 8'd3, 8'd2, 8'd1}, 0);
    wait_done();

    // Backpressure.
    ifc.b_data = '0;
    sb.push_back(EXP_BASIC);
    do_start();
    stream({8'd10, 8'd10, 8'd10, 8'd10}, 2);
    wait_done();

    // Start ignored in ACCUM and POST.
    sb.push_back(EXP_BASIC);
    do_start();
    send_beat(8'd10, 0);
    send_beat(8'd10, 1);
    ifc.start = 1'b1;
    send_beat(8'd10, 2);
    ifc.start = 1'b0;
    send_beat(8'd10, 3);
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    @(negedge clk);
    chk("post_start_ignored", 80'(ifc.in_ready), 80'd0);
    wait_done();

    // Start in the out_valid cycle is honoured.
    sb.push_back(EXP_BASIC);
    do_start();
    stream({8'd10, 8'd10, 8'd10, 8'd10}, 0);
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    sb.push_back(EXP_BASIC);
    @(negedge clk);
    chk("ov_with_start", 80'(ifc.out_valid), 80'd1);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    @(negedge clk);
    chk("restart_in_ready", 80'(ifc.in_ready), 80'd1);
    @(posedge clk);
    #1;
    stream({8'd10, 8'd10, 8'd10, 8'd10}, 0);
    wait_done();

    // Abort mid-accumulation.
    do_start();
    send_beat(8'd10, 0);
    send_beat(8'd10, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 80'(ifc.in_ready), 80'd0);
    chk("abort_scores", ifc.scores, 80'd0);
    chk("abort_busy", 80'(ifc.busy), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_idle", 80'(ifc.busy), 80'd0);
    @(posedge clk);
    #1;
    sb.push_back(EXP_BASIC);
    do_start();
    stream({8'd10, 8'd10, 8'd10, 8'd10}, 0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_layer_mac.md
# output_layer_mac

Serial dense output layer that produces the ten 8-bit class scores consumed by the argmax classifier stage. The block streams N_IN hidden-layer activations, one per handshake. For each activation it multiply-accumulates against ten signed weights fetched in parallel from an external weight memory. After the last activation it applies bias, scaling, ReLU and saturation, then presents the packed 80-bit score vector with a one-cycle valid pulse.

## Interface
- N_IN, 64: activations per inference (≥2).
- ACC_W, 24: accumulator width per class, signed. Must be ≥ 17 + clog2(N_IN). Overflow is not detected.
- SHIFT, 7: arithmetic right shift applied to each accumulator before clamping.
- AW, clog2(N_IN): weight address width.

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin an inference. Honoured only in IDLE.
- in_valid  in  1  activation present.
- in_ready  out  1  high only in ACCUM.
- in_data  in  8  activation, unsigned.
- w_addr  out  AW  index of the activation currently expected; equals the internal count.
- w_data  in  80  ten signed 8-bit weights for w_addr, class k in bits [8k+7:8k]. Combinational read, valid in the same cycle as w_addr.
- b_data  in  80  ten signed 8-bit biases, class k in bits [8k+7:8k]. Sampled at start.
- scores  out  80  registered class scores, unsigned, class k in bits [8k+7:8k].
- out_valid  out  1  one-cycle pulse when scores update.
- busy  out  1  high in ACCUM and POST.

## Operation
- Reset (asynchronous, rst_n=0): state IDLE, count 0, all accumulators 0, scores 0, out_valid 0, in_ready 0, busy 0.
- FSM states: IDLE, ACCUM, POST.
- IDLE, start=1:
  - acc[k] ← sign-extended b_data[k].
  - count ← 0.
  - go to ACCUM.
- ACCUM: each cycle with in_valid & in_ready:
  - acc[k] ← acc[k] + ({1'b0,in_data} × signed w_data[k]), for all k in parallel. The product is a 17-bit signed value, sign-extended to ACC_W.
  - count ← count+1.
  - When the accepted beat has count = N_IN−1, go to POST and set count to 0.
  - Cycles without a handshake change nothing.
- POST (exactly one cycle):
  - t = acc[k] >>> SHIFT.
  - scores[k] ← 0 if t<0; 255 if t>255; t otherwise.
  - out_valid ← 1.
  - go to IDLE.
- scores holds its value until the next POST. It is never cleared except by reset.
- start outside IDLE is ignored and not queued. start in the same cycle out_valid is high is honoured, since the state is IDLE.
- in_data and w_data are ignored outside accepting beats. Stray in_valid in IDLE is not accepted.
- Output ordering is fixed: index k of the downstream argmax is class k.

## Timing
- start sampled at edge E0 → in_ready high from the cycle after E0.
- With in_valid held high, activations are accepted at edges E1..E_N_IN.
- POST occupies the cycle after E_N_IN. scores and out_valid register at edge E_N_IN+1.
- out_valid is high for exactly one cycle, after E_N_IN+1. Minimum inference is N_IN+2 edges from start.
- General rule: out_valid rises at the second edge after the edge that accepts the last activation.
- w_addr changes only on accepting edges. The weight memory must resolve w_data combinationally within the same cycle.
- Reset asserted mid-ACCUM or mid-POST aborts immediately: no out_valid, scores go to 0.

## Test plan
- Reset: hold rst_n=0 with random inputs → scores=0, out_valid=0, in_ready=0, busy=0. Release, wait 5 cycles with no start → outputs unchanged.
- Basic: N_IN=4, SHIFT=2, bias 0, class-k weight = k, in_data=10 streamed back-to-back → scores bytes 0,10,20,…,90 (class 0..9). out_valid is a single pulse at the 2nd edge after the 4th accept.
- Clamping, N_IN=4, SHIFT=2:
  - class0 weight −1, inputs 10 → score 0 (ReLU).
  - class9 weight 127, bias 127, inputs 255 → acc 129667 → score 255.
  - class5 bias −4, all weights 0 → 0.
- Backpressure: basic stimulus with in_valid asserted every third cycle → identical scores. w_addr advances only on handshakes. busy stays high throughout.
- Ignored start: pulse start during ACCUM and during POST → no restart; the result matches the basic case. Then pulse start in the out_valid cycle → new inference begins, in_ready rises the next cycle.
- Abort: assert rst_n=0 after 2 accepted activations → in_ready=0 and scores=0 immediately, no out_valid. A following full inference produces correct scores.
